// File: rtl/scoreboard_decoder.sv
// rtl/scoreboard_decoder.sv - debounced two-digit 7-segment score decoder with score-change event FIFO
module scoreboard_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       clk_1khz_i,
    input  logic       rst_i,
    input  logic [6:0] seg_tens_i,
    input  logic [6:0] seg_ones_i,
    input  logic       evt_ready_i,
    output logic       evt_valid_o,
    output logic [6:0] evt_score_o,
    output logic       evt_up_o,
    output logic [6:0] score_o,
    output logic       err_invalid_o,
    output logic       overflow_o
);

    localparam int           AW       = $clog2(FIFO_DEPTH);
    localparam logic [3:0]   STABLE   = 4'(STABLE_CYCLES);
    localparam logic [AW:0]  CNT_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [13:0]  SAMPLE_RST = {7'h00, 7'h3F};

    // Returns {valid, digit}; a blank tens digit is leading-zero suppression.
    function automatic logic [4:0] decode_digit(input logic [6:0] seg, input logic blank_ok);
        case (seg)
            7'h3F:   decode_digit = {1'b1, 4'd0};
            7'h06:   decode_digit = {1'b1, 4'd1};
            7'h5B:   decode_digit = {1'b1, 4'd2};
            7'h4F:   decode_digit = {1'b1, 4'd3};
            7'h66:   decode_digit = {1'b1, 4'd4};
            7'h6D:   decode_digit = {1'b1, 4'd5};
            7'h7D:   decode_digit = {1'b1, 4'd6};
            7'h07:   decode_digit = {1'b1, 4'd7};
            7'h7F:   decode_digit = {1'b1, 4'd8};
            7'h6F:   decode_digit = {1'b1, 4'd9};
            7'h00:   decode_digit = {blank_ok, 4'd0};
            default: decode_digit = 5'd0;
        endcase
    endfunction

    logic [13:0]  sample_q;
    logic [3:0]   run_cnt_q;
    logic [6:0]   score_q;
    logic         err_q;
    logic         ovf_q;
    logic [7:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]  count_q;

    logic        same;
    logic        accept;
    logic [4:0]  tens_dec;
    logic [4:0]  ones_dec;
    logic        pat_valid;
    logic [6:0]  value;
    logic        push;
    logic        pop;
    logic        full;
    logic        do_push;

    always_comb begin
        same      = ({seg_tens_i, seg_ones_i} == sample_q);
        accept    = same && (run_cnt_q == STABLE - 4'd1);
        tens_dec  = decode_digit(sample_q[13:7], 1'b1);
        ones_dec  = decode_digit(sample_q[6:0], 1'b0);
        pat_valid = tens_dec[4] && ones_dec[4];
        value     = 7'(tens_dec[3:0]) * 7'd10 + 7'(ones_dec[3:0]);
        full      = (count_q == CNT_FULL);
        pop       = evt_valid_o && evt_ready_i;
        push      = accept && pat_valid && (value != score_q);
        // A full FIFO still accepts a push when the head leaves on the same edge.
        do_push   = push && (!full || pop);
    end

    always_ff @(posedge clk_1khz_i or posedge rst_i) begin
        if (rst_i) begin
            sample_q  <= SAMPLE_RST;
            run_cnt_q <= STABLE;
            score_q   <= 7'd0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            sample_q <= {seg_tens_i, seg_ones_i};
            if (!same)
                run_cnt_q <= 4'd0;
            else if (run_cnt_q != STABLE)
                run_cnt_q <= run_cnt_q + 4'd1;
            err_q <= accept && !pat_valid;
            if (accept && pat_valid)
                score_q <= value;
            if (push && !do_push)
                ovf_q <= 1'b1;
            if (do_push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !pop)
                count_q <= count_q + 1'b1;
            else if (!do_push && pop)
                count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_1khz_i) begin
        if (do_push)
            mem[wr_ptr_q] <= {(value > score_q), value};
    end

    always_comb begin
        evt_valid_o   = (count_q != '0);
        evt_score_o   = evt_valid_o ? mem[rd_ptr_q][6:0] : 7'd0;
        evt_up_o      = evt_valid_o ? mem[rd_ptr_q][7] : 1'b0;
        score_o       = score_q;
        err_invalid_o = err_q;
        overflow_o    = ovf_q;
    end

endmodule

// File: tb/tb_scoreboard_decoder.sv
// tb/tb_scoreboard_decoder.sv - scoreboard-queue bench for scoreboard_decoder
module tb_scoreboard_decoder;

    localparam int STABLE = 4;
    localparam int DEPTH  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg_tens = 7'h00;
    logic [6:0] seg_ones = 7'h3F;
    logic       evt_ready = 1'b0;
    logic       evt_valid;
    logic [6:0] evt_score;
    logic       evt_up;
    logic [6:0] score;
    logic       err_invalid;
    logic       overflow;

    int total = 0;
    int bad   = 0;

    logic [7:0]  exp_q[$];
    logic [13:0] last_pat;
    int          m_score;
    bit          m_ovf;

    scoreboard_decoder #(.STABLE_CYCLES(STABLE), .FIFO_DEPTH(DEPTH)) dut (
        .clk_1khz_i   (clk),
        .rst_i        (rst),
        .seg_tens_i   (seg_tens),
        .seg_ones_i   (seg_ones),
        .evt_ready_i  (evt_ready),
        .evt_valid_o  (evt_valid),
        .evt_score_o  (evt_score),
        .evt_up_o     (evt_up),
        .score_o      (score),
        .err_invalid_o(err_invalid),
        .overflow_o   (overflow)
    );

    always #5 clk = ~clk;

    function automatic int seg2dig(input logic [6:0] s, input bit is_tens);
        logic [6:0] tbl [10];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        for (int d = 0; d < 10; d++)
            if (tbl[d] == s) return d;
        if (is_tens && s == 7'h00) return 0;
        return -1;
    endfunction

    // One clock edge: pop check at the falling edge, model update, output check after the rising edge.
    task automatic tick(input bit is_acc);
        logic [7:0] head;
        int t, o, v;
        bit inv;
        @(negedge clk);
        total++;
        if (evt_valid !== (exp_q.size() != 0)) begin
            bad++;
            $display("FAIL evt_valid: got %0b want %0b", evt_valid, exp_q.size() != 0);
        end
        if (evt_valid && evt_ready && exp_q.size() != 0) begin
            head = exp_q.pop_front();
            total++;
            if ({evt_up, evt_score} !== head) begin
                bad++;
                $display("FAIL evt_data: got score=%0d up=%0b want score=%0d up=%0b",
                         evt_score, evt_up, head[6:0], head[7]);
            end
        end
        inv = 1'b0;
        if (is_acc) begin
            t = seg2dig(last_pat[13:7], 1'b1);
            o = seg2dig(last_pat[6:0], 1'b0);
            if (t < 0 || o < 0) begin
                inv = 1'b1;
            end else begin
                v = t * 10 + o;
                if (v != m_score) begin
                    if (exp_q.size() < DEPTH) exp_q.push_back({(v > m_score), 7'(v)});
                    else m_ovf = 1'b1;
                    m_score = v;
                end
            end
        end
        @(posedge clk);
        #1;
        total++;
        if (score !== 7'(m_score) || overflow !== m_ovf || err_invalid !== inv) begin
            bad++;
            $display("FAIL outputs: got score=%0d ovf=%0b err=%0b want score=%0d ovf=%0b err=%0b",
                     score, overflow, err_invalid, m_score, m_ovf, inv);
        end
    endtask

    task automatic hold(input logic [6:0] t, input logic [6:0] o, input int n, input bit pulse_ready);
        bit changed;
        changed  = ({t, o} != last_pat);
        seg_tens = t;
        seg_ones = o;
        last_pat = {t, o};
        for (int i = 1; i <= n; i++) begin
            if (pulse_ready && i == STABLE + 1) evt_ready = 1'b1;
            tick(changed && i == STABLE + 1);
            if (pulse_ready && i == STABLE + 1) evt_ready = 1'b0;
        end
    endtask

    task automatic check_reset_values(input string tag);
        total++;
        if (evt_valid !== 1'b0 || evt_score !== 7'd0 || evt_up !== 1'b0 || score !== 7'd0 ||
            err_invalid !== 1'b0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL %s: got valid=%0b evt=%0d up=%0b score=%0d err=%0b ovf=%0b want all zero",
                     tag, evt_valid, evt_score, evt_up, score, err_invalid, overflow);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        check_reset_values("reset_async");
        exp_q.delete();
        m_score  = 0;
        m_ovf    = 1'b0;
        seg_tens = 7'h00;
        seg_ones = 7'h3F;
        last_pat = {7'h00, 7'h3F};
        evt_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        evt_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick(1'b0);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: got %0d left want 0", exp_q.size());
        end
        tick(1'b0);
        evt_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        check_reset_values("reset_release");
        hold(7'h00, 7'h3F, 8, 1'b0);
    endtask

    task automatic test_first_score();
        evt_ready = 1'b1;
        hold(7'h00, 7'h5B, 7, 1'b0);
    endtask

    task automatic test_glitch();
        hold(7'h3F, 7'h07, 2, 1'b0);
        hold(7'h00, 7'h5B, 7, 1'b0);
    endtask

    task automatic test_wrap();
        evt_ready = 1'b1;
        hold(7'h6F, 7'h6F, 6, 1'b0);
        hold(7'h00, 7'h3F, 6, 1'b0);
    endtask

    task automatic test_invalid();
        hold(7'h3F, 7'h49, 6, 1'b0);
        hold(7'h00, 7'h00, 6, 1'b0);
    endtask

    task automatic test_full_push_pop();
        do_reset();
        hold(7'h06, 7'h06, 6, 1'b0);
        hold(7'h5B, 7'h5B, 6, 1'b0);
        hold(7'h4F, 7'h4F, 6, 1'b0);
        hold(7'h66, 7'h66, 6, 1'b0);
        hold(7'h6D, 7'h6D, 6, 1'b1);
        drain();
    endtask

    task automatic test_overflow();
        do_reset();
        hold(7'h06, 7'h06, 6, 1'b0);
        hold(7'h5B, 7'h5B, 6, 1'b0);
        hold(7'h4F, 7'h4F, 6, 1'b0);
        hold(7'h66, 7'h66, 6, 1'b0);
        hold(7'h6D, 7'h6D, 6, 1'b0);
        drain();
        hold(7'h7D, 7'h7D, 6, 1'b0);
        drain();
    endtask

    task automatic test_reset_mid_run();
        hold(7'h7F, 7'h7F, 6, 1'b0);
        hold(7'h4F, 7'h4F, 2, 1'b0);
        do_reset();
        hold(7'h00, 7'h3F, 8, 1'b0);
        hold(7'h5B, 7'h5B, 6, 1'b0);
        drain();
    endtask

    initial begin
        m_score  = 0;
        m_ovf    = 1'b0;
        last_pat = {7'h00, 7'h3F};
        test_reset();
        test_first_score();
        test_glitch();
        test_wrap();
        test_invalid();
        test_full_push_pop();
        test_overflow();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scoreboard_decoder.md
SCOREBOARD_DECODER -- requirements
Module: scoreboard_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4 (range 2..15): consecutive equal-sample edges required to accept a display pattern.
REQ-002 Parameter FIFO_DEPTH, default 4 (power of two, 2..8): score-change event queue depth.
REQ-003 clk_1khz_i  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-high.
REQ-005 seg_tens_i  in  7  tens-digit segments {g,f,e,d,c,b,a}, active-high.
REQ-006 seg_ones_i  in  7  ones-digit segments, same encoding.
REQ-007 evt_ready_i  in  1  consumer accepts the head event.
REQ-008 evt_valid_o  out  1  head event available.
REQ-009 evt_score_o  out  7  head event score, binary 0..99.
REQ-010 evt_up_o  out  1  head event direction: 1 = new score > previous score.
REQ-011 score_o  out  7  last accepted score, binary 0..99.
REQ-012 err_invalid_o  out  1  one-cycle pulse on acceptance of an undecodable pattern.
REQ-013 overflow_o  out  1  sticky: an event was dropped because the FIFO was full.

Function
REQ-014 Digit map: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
REQ-015 Tens 0x00 (blank, leading-zero suppression) decodes as 0; ones 0x00 is invalid; any other unlisted pattern on either digit is invalid.
REQ-016 A 14-bit sample register loads {seg_tens_i, seg_ones_i} on every edge.
REQ-017 Run counter: cleared when the inputs differ from the sample register; incremented (saturating at STABLE_CYCLES) when they are equal.
REQ-018 Acceptance occurs exactly once per stable run, on the edge where the run counter reaches STABLE_CYCLES.
REQ-019 For inputs changed before edge 1 and then held, the sample register loads at edge 1 and acceptance occurs at edge STABLE_CYCLES+1.
REQ-020 Any input glitch shorter than the acceptance window SHALL cause no acceptance and SHALL restart the count.
REQ-021 Valid acceptance with decoded value V != score_o: score_o <= V on the acceptance edge; event {V, V>score_o} pushed on the same edge.
REQ-022 Valid acceptance with V == score_o: no event, no output change.
REQ-023 Invalid acceptance: err_invalid_o high for exactly the following cycle; score_o and FIFO unchanged.
REQ-024 Wrap-around 99->0 is an ordinary decrease: evt_up_o = 0.
REQ-025 FIFO: evt_valid_o = (FIFO not empty); evt_score_o/evt_up_o come from the head entry and are held stable while evt_valid_o=1 and evt_ready_i=0.
REQ-026 Pop occurs on an edge with evt_valid_o=1 and evt_ready_i=1; evt_ready_i while empty is ignored.
REQ-027 A pushed event is visible on evt_valid_o immediately after the push edge if the FIFO was empty; push and pop never coalesce entries.
REQ-028 Push while full without simultaneous pop: new event dropped, score_o still updated, overflow_o set until reset.
REQ-029 Push and pop on the same edge while full: both performed, no overflow.
REQ-030 Events leave in push order.

Reset
REQ-031 rst_i asserted: immediately, without a clock edge, FIFO empty, evt_valid_o=0, score_o=0, err_invalid_o=0, overflow_o=0, run counter=STABLE_CYCLES (run already accepted), sample register={0x00,0x3F}.
REQ-032 evt_score_o=0 and evt_up_o=0 while the FIFO is empty after reset.
REQ-033 Reset asserted mid-run or with a non-empty FIFO discards all pending state; the first acceptance after release follows REQ-019.
REQ-034 Holding "blank/0" through reset release generates no event.

Verification (STABLE_CYCLES=4, FIFO_DEPTH=4)
REQ-035 Drive {0x00,0x5B} ("2") from reset; hold evt_ready_i=1 -> score_o=2 after edge 5; evt_valid_o=1 with score 2, up=1; then pops.
REQ-036 From score 2, drive "07" for 2 edges, then back to "2" -> no event, score_o stays 2, run count restarts.
REQ-037 Drive {0x6F,0x6F} ("99") then {0x00,0x3F} ("0"), each held 6 edges -> events (99, up=1) then (0, up=0).
REQ-038 Drive {0x3F,0x49} (invalid) for 6 edges -> single err_invalid_o pulse; score_o unchanged; no event.
REQ-039 With evt_ready_i=0, apply 5 distinct valid scores -> 4 events queued in order, fifth dropped, overflow_o=1, score_o = fifth value.
REQ-040 With the FIFO full, pulse evt_ready_i on the acceptance edge of a sixth value -> no overflow on that edge, sixth value queued last; assert rst_i mid-run -> all outputs at reset values without a clock edge.
